// File: rtl/ssd1306_sequencer.sv
// SSD1306 128x64 OLED control sequencer: panel power-up and frame streaming.
// Optional power-up sequence is built when SSD1306_POWER_UP_EN is defined.
module ssd1306_sequencer #(
    parameter int RST_CYCLES = 1000,
    parameter int FB_BYTES   = 1024,
    parameter int FB_AW      = $clog2(FB_BYTES)
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic             sr_start,
    output logic [7:0]       sr_data,
    input  logic             sr_ready,
    output logic             oled_dc,
    output logic             oled_cs_n,
    output logic             oled_rst_n,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [7:0]       fb_data,
    input  logic             frame_start,
    output logic             busy,
    output logic             frame_done
);

`ifdef SSD1306_POWER_UP_EN
    typedef enum logic [3:0] {
        RST_LO, RST_WAIT, INIT_SEND, INIT_WAIT,
        IDLE, WIN_SEND, WIN_WAIT, FETCH,
        DAT_SEND, DAT_WAIT, DONE
    } state_t;

    localparam state_t RST_STATE = RST_LO;
    localparam logic   RST_BUSY  = 1'b1;
    localparam logic   RST_RSTN  = 1'b0;
    localparam int     CNT_W     = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
`else
    typedef enum logic [3:0] {
        IDLE, WIN_SEND, WIN_WAIT, FETCH,
        DAT_SEND, DAT_WAIT, DONE
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BUSY  = 1'b0;
    localparam logic   RST_RSTN  = 1'b1;
`endif

    localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_BYTES - 1);

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic             sr_start_q, sr_start_d;
    logic [7:0]       sr_data_q, sr_data_d;
    logic             dc_q, dc_d;
    logic             cs_n_q, cs_n_d;
    logic             rst_n_q, rst_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SSD1306_POWER_UP_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Panel initialisation command list, sent once after the reset pulse.
    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:    init_byte = 8'hAE;
            5'd1:    init_byte = 8'hD5;
            5'd2:    init_byte = 8'h80;
            5'd3:    init_byte = 8'hA8;
            5'd4:    init_byte = 8'h3F;
            5'd5:    init_byte = 8'hD3;
            5'd6:    init_byte = 8'h00;
            5'd7:    init_byte = 8'h40;
            5'd8:    init_byte = 8'h8D;
            5'd9:    init_byte = 8'h14;
            5'd10:   init_byte = 8'h20;
            5'd11:   init_byte = 8'h00;
            5'd12:   init_byte = 8'hA1;
            5'd13:   init_byte = 8'hC8;
            5'd14:   init_byte = 8'hDA;
            5'd15:   init_byte = 8'h12;
            5'd16:   init_byte = 8'h81;
            5'd17:   init_byte = 8'hCF;
            5'd18:   init_byte = 8'hD9;
            5'd19:   init_byte = 8'hF1;
            5'd20:   init_byte = 8'hDB;
            5'd21:   init_byte = 8'h40;
            5'd22:   init_byte = 8'hA4;
            5'd23:   init_byte = 8'hA6;
            5'd24:   init_byte = 8'hAF;
            default: init_byte = 8'h00;
        endcase
    endfunction
`endif

    // Full-screen column/page window preceding every frame.
    function automatic logic [7:0] win_byte(input logic [4:0] i);
        case (i)
            5'd0:    win_byte = 8'h21;
            5'd1:    win_byte = 8'h00;
            5'd2:    win_byte = 8'h7F;
            5'd3:    win_byte = 8'h22;
            5'd4:    win_byte = 8'h00;
            5'd5:    win_byte = 8'h07;
            default: win_byte = 8'h00;
        endcase
    endfunction

    // Next-state logic; outputs are computed one cycle ahead so they leave flops.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fb_addr_d  = fb_addr_q;
        sr_start_d = 1'b0;
        sr_data_d  = sr_data_q;
        dc_d       = dc_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
`ifdef SSD1306_POWER_UP_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
`ifdef SSD1306_POWER_UP_EN
            RST_LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    idx_d      = 5'd0;
                    state_d    = INIT_SEND;
                    sr_start_d = 1'b1;
                    sr_data_d  = init_byte(5'd0);
                    dc_d       = 1'b0;
                    cs_n_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT_SEND: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (sr_ready) begin
                    if (idx_q == 5'd24) begin
                        state_d = IDLE;
                        cs_n_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        state_d    = INIT_SEND;
                        sr_start_d = 1'b1;
                        sr_data_d  = init_byte(idx_q + 5'd1);
                        dc_d       = 1'b0;
                        cs_n_d     = 1'b0;
                    end
                end
            end
`endif
            IDLE: begin
                if (frame_start) begin
                    idx_d      = 5'd0;
                    state_d    = WIN_SEND;
                    sr_start_d = 1'b1;
                    sr_data_d  = win_byte(5'd0);
                    dc_d       = 1'b0;
                    cs_n_d     = 1'b0;
                end
            end
            WIN_SEND: state_d = WIN_WAIT;
            WIN_WAIT: begin
                if (sr_ready) begin
                    if (idx_q == 5'd5) begin
                        state_d   = FETCH;
                        fb_addr_d = '0;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        state_d    = WIN_SEND;
                        sr_start_d = 1'b1;
                        sr_data_d  = win_byte(idx_q + 5'd1);
                        dc_d       = 1'b0;
                        cs_n_d     = 1'b0;
                    end
                end
            end
            FETCH: begin
                state_d    = DAT_SEND;
                sr_start_d = 1'b1;
                sr_data_d  = fb_data;
                dc_d       = 1'b1;
                cs_n_d     = 1'b0;
            end
            DAT_SEND: state_d = DAT_WAIT;
            DAT_WAIT: begin
                if (sr_ready) begin
                    if (fb_addr_q == FB_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cs_n_d  = 1'b1;
                    end else begin
                        fb_addr_d = fb_addr_q + 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = RST_STATE;
        endcase
        busy_d = (state_d != IDLE);
`ifdef SSD1306_POWER_UP_EN
        rst_n_d = (state_d != RST_LO);
`else
        rst_n_d = 1'b1;
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= RST_STATE;
            idx_q      <= 5'd0;
            fb_addr_q  <= '0;
            sr_start_q <= 1'b0;
            sr_data_q  <= 8'h00;
            dc_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            rst_n_q    <= RST_RSTN;
            busy_q     <= RST_BUSY;
            done_q     <= 1'b0;
`ifdef SSD1306_POWER_UP_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fb_addr_q  <= fb_addr_d;
            sr_start_q <= sr_start_d;
            sr_data_q  <= sr_data_d;
            dc_q       <= dc_d;
            cs_n_q     <= cs_n_d;
            rst_n_q    <= rst_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SSD1306_POWER_UP_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign sr_start   = sr_start_q;
    assign sr_data    = sr_data_q;
    assign oled_dc    = dc_q;
    assign oled_cs_n  = cs_n_q;
    assign oled_rst_n = rst_n_q;
    assign fb_addr    = fb_addr_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ssd1306_sequencer.sv
// Directed bench for ssd1306_sequencer with a shift-register model,
// framebuffer model and protocol checker.
module tb_ssd1306_sequencer;
    localparam int RC = 4;
    localparam int FB = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sr_start;
    logic [7:0]    sr_data;
    logic          sr_ready = 1'b1;
    logic          dc;
    logic          cs_n;
    logic          rst_n;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          frame_start = 1'b0;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int sr_cnt = 0;
    logic [8:0] cap[$];
    logic dc_p = 1'b0;
    logic cs_p = 1'b1;

    logic [8:0] fexp[10] = '{9'h021, 9'h000, 9'h07F, 9'h022, 9'h000,
                             9'h007, 9'h15A, 9'h15B, 9'h158, 9'h159};
`ifdef SSD1306_POWER_UP_EN
    logic [7:0] rom[25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3,
                            8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00,
                            8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                            8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                            8'hAF};
    localparam logic EXP_RSTN = 1'b0;
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_RSTN = 1'b1;
    localparam logic EXP_BUSY = 1'b0;
`endif

    always #5 clk = ~clk;

    ssd1306_sequencer #(
        .RST_CYCLES(RC),
        .FB_BYTES  (FB)
    ) dut (
        .clk_in     (clk),
        .reset      (reset),
        .sr_start   (sr_start),
        .sr_data    (sr_data),
        .sr_ready   (sr_ready),
        .oled_dc    (dc),
        .oled_cs_n  (cs_n),
        .oled_rst_n (rst_n),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_start(frame_start),
        .busy       (busy),
        .frame_done (frame_done)
    );

    assign fb_data = {6'b0, fb_addr} ^ 8'h5A;

    // Shift register: busy from the cycle after start until 9 cycles later.
    always @(posedge clk) begin
        if (reset) begin
            sr_ready <= 1'b1;
            sr_cnt   <= 0;
        end else if (sr_start) begin
            sr_ready <= 1'b0;
            sr_cnt   <= 8;
            cap.push_back({dc, sr_data});
        end else if (sr_cnt > 0) begin
            sr_cnt <= sr_cnt - 1;
            if (sr_cnt == 1) sr_ready <= 1'b1;
        end
    end

    // Protocol checker sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (sr_start && !sr_ready) viol = viol + 1;
            if ((dc !== dc_p || cs_n !== cs_p) && !sr_ready) viol = viol + 1;
            if (busy === 1'b0 && cs_n !== 1'b1) viol = viol + 1;
        end
        dc_p = dc;
        cs_p = cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_start"}, sr_start, 0);
        chk({tag, "_data"}, sr_data, 0);
        chk({tag, "_dc"}, dc, 0);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_rst_n"}, rst_n, EXP_RSTN);
        chk({tag, "_busy"}, busy, EXP_BUSY);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

`ifdef SSD1306_POWER_UP_EN
    task automatic power_up();
        int c;
        cap.delete();
        step(3);
        chk("pu_rst_lo_c3", rst_n, 0);
        step(1);
        chk("pu_rst_hi_c4", rst_n, 1);
        chk("pu_no_start_c4", sr_start, 0);
        step(4);
        chk("pu_start_c8", sr_start, 1);
        chk("pu_data_c8", sr_data, 8'hAE);
        chk("pu_dc_c8", dc, 0);
        chk("pu_cs_c8", cs_n, 0);
        c = 8;
        while (busy !== 1'b0 && c < 400) begin
            step(1);
            c++;
        end
        chk("pu_busy_fall", c, 258);
        chk("pu_cs_idle", cs_n, 1);
        chk("pu_count", cap.size(), 25);
        for (int i = 0; i < 25 && i < cap.size(); i++)
            chk($sformatf("pu_byte%0d", i), cap[i], {1'b0, rom[i]});
    endtask
`endif

    // Runs one frame from an IDLE cycle (relative cycle 0).
    task automatic run_frame(input string tag, input bit hold);
        int c;
        cap.delete();
        frame_start = 1'b1;
        step(1);
        chk({tag, "_start_c1"}, sr_start, 1);
        chk({tag, "_data_c1"}, sr_data, 8'h21);
        chk({tag, "_busy_c1"}, busy, 1);
        if (!hold) frame_start = 1'b0;
        c = 1;
        while (frame_done !== 1'b1 && c < 300) begin
            if (!hold) frame_start = (c == 40);
            step(1);
            c++;
            if (c == 62) chk({tag, "_dat_start_c62"}, sr_start, 1);
        end
        frame_start = hold;
        chk({tag, "_done_cycle"}, c, 61 + 11 * FB);
        chk({tag, "_done_cs"}, cs_n, 1);
        chk({tag, "_count"}, cap.size(), 10);
        for (int i = 0; i < 10 && i < cap.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), cap[i], fexp[i]);
        step(1);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_done_pulse"}, frame_done, 0);
        chk({tag, "_idle_cs"}, cs_n, 1);
        chk({tag, "_idle_nostart"}, sr_start, 0);
    endtask

    initial begin
        int n;
        int k;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        reset_vals("rst0");
`ifdef SSD1306_POWER_UP_EN
        power_up();
`endif

        run_frame("hold", 1'b1);
        step(1);
        chk("second_start", sr_start, 1);
        chk("second_data", sr_data, 8'h21);
        chk("second_busy", busy, 1);
        frame_start = 1'b0;

        n = 0;
        k = 0;
        while (k < 3 && n < 300) begin
            step(1);
            n++;
            if (sr_start === 1'b1 && dc === 1'b1) k++;
        end
        chk("third_data_seen", k, 3);
        chk("third_data_val", sr_data, 8'h58);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        reset_vals("abort");
`ifdef SSD1306_POWER_UP_EN
        power_up();
`endif

        run_frame("pulse", 1'b0);
        step(2);
        chk("stay_idle_busy", busy, 0);
        chk("stay_idle_start", sr_start, 0);
        chk("protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ssd1306_sequencer.md
# ssd1306_sequencer

Control sequencer that drives the 8-bit SPI shift register for the SSD1306 128x64 OLED. It performs the panel power-up: a hardware reset pulse and then a fixed initialisation command list from an internal ROM. On request it streams one full frame: a column/page window command set, then every framebuffer byte. It owns the shift register's `start`/`data_in`, the OLED `D/C#`, `CS#` and `RES#` pins, and the framebuffer read port.

## Interface
Parameters:
- `RST_CYCLES`, 1000: length of the `oled_rst_n` low pulse, and of the following settle wait, in `clk_in` cycles.
- `FB_BYTES`, 1024: framebuffer bytes per frame (128x64/8). `FB_AW = $clog2(FB_BYTES)`.

Ports:
- `clk_in` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `sr_start` out 1: one-cycle load strobe to the shift register.
- `sr_data` out 8: byte for the shift register; valid when `sr_start`=1.
- `sr_ready` in 1: shift register idle.
- `oled_dc` out 1: 0 = command, 1 = data.
- `oled_cs_n` out 1: chip select, active low.
- `oled_rst_n` out 1: panel reset, active low.
- `fb_addr` out FB_AW: framebuffer read address.
- `fb_data` in 8: framebuffer byte, valid one cycle after `fb_addr`.
- `frame_start` in 1: request a frame transfer; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when a frame completes.

## Operation
- States: RST_LO, RST_WAIT, INIT_SEND, INIT_WAIT, IDLE, WIN_SEND, WIN_WAIT, FETCH, DAT_SEND, DAT_WAIT, DONE.
- Reset values: state RST_LO, `sr_start`=0, `sr_data`=0, `oled_dc`=0, `oled_cs_n`=1, `oled_rst_n`=0, `fb_addr`=0, `busy`=1, `frame_done`=0. All counters and indices are 0.
- RST_LO:
  - `oled_rst_n`=0 for RST_CYCLES cycles.
  - Then RST_WAIT: `oled_rst_n`=1 for RST_CYCLES cycles.
  - Then INIT_SEND with index 0.
- Init ROM, 25 bytes, in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- *_SEND states:
  - Drive `sr_start`=1 and `sr_data` = the current byte for one cycle.
  - Set `oled_dc` (0 for INIT/WIN, 1 for DAT) and `oled_cs_n`=0 in the same cycle.
  - Go to the matching *_WAIT state.
- *_WAIT states: stay until `sr_ready`=1, then advance the index.
  - INIT: after byte 24, go to IDLE and drive `oled_cs_n`=1.
  - WIN: send 6 bytes, 21 00 7F 22 00 07, then go to FETCH with `fb_addr`=0.
  - DAT: if `fb_addr`=FB_BYTES-1, go to DONE; otherwise increment `fb_addr` and go to FETCH.
- FETCH: one cycle with `fb_addr` stable. DAT_SEND then uses `fb_data` directly as `sr_data`.
- IDLE: `frame_start`=1 moves to WIN_SEND with index 0. `frame_start` is ignored in all other states (no queueing).
- DONE: `frame_done`=1 and `oled_cs_n`=1 for one cycle, then IDLE.
- `oled_dc` and `oled_cs_n` change only in *_SEND, IDLE-entry or DONE cycles. They therefore never change while `sr_ready`=0.
- `sr_start` is never asserted when `sr_ready`=0.
- `reset` mid-operation aborts immediately to the reset values. The shift register shares `reset`, so no partial byte survives.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The shift register drops `sr_ready` the cycle after `sr_start` and raises it 9 cycles after `sr_start`. WAIT states need no extra guard cycle.
- Command byte period: 10 cycles (SEND 1 + WAIT 9).
- Framebuffer byte period: 11 cycles (FETCH 1 + SEND 1 + WAIT 9).
- Power-up: first `sr_start` occurs 2*RST_CYCLES cycles after `reset` falls. IDLE is reached 250 cycles later (25 x 10).
- Frame, with `frame_start` sampled in IDLE at cycle 0:
  - First `sr_start` at cycle 1.
  - First data `sr_start` at cycle 62.
  - `frame_done` at cycle 61 + 11*FB_BYTES, i.e. 11325 for the defaults.
- `busy` rises in the cycle after `frame_start` is sampled. It falls in the cycle after `frame_done`.

## Configuration
- `SSD1306_POWER_UP_EN` defined:
  - Full power-up behaviour as above.
  - The reset state is RST_LO.
- `SSD1306_POWER_UP_EN` undefined:
  - RST_*/INIT_* states and the init ROM are not compiled.
  - The reset state is IDLE, with `oled_rst_n`=1 constantly and `busy`=0 after reset.
  - Frame behaviour and frame timing are unchanged.

## Test plan
- Power-up with RST_CYCLES=4:
  - `oled_rst_n` is low for cycles 0-3 after reset and high from cycle 4.
  - First `sr_start` at cycle 8 with `sr_data`=AE, `oled_dc`=0.
  - 25 bytes matching the ROM order.
  - `busy` falls at cycle 258.
- Frame with FB_BYTES=4 and `fb_data`=addr^8'h5A (model shift register attached):
  - Serial bytes: 21 00 7F 22 00 07 5A 5B 58 59.
  - `oled_dc` is 0 for the first 6 bytes and 1 for the last 4.
  - `frame_done` fires at cycle 105.
- `frame_start` held high through the whole frame: exactly one frame is sent. A second frame starts only from the IDLE cycle after DONE.
- `reset` asserted in the 3rd data byte:
  - Next cycle: `oled_cs_n`=1, `sr_start`=0, `oled_rst_n`=0.
  - The power-up sequence replays in full.
- Protocol checker on every run:
  - No `sr_start` while `sr_ready`=0.
  - No `oled_dc`/`oled_cs_n` edge while `sr_ready`=0.
  - `oled_cs_n`=1 in IDLE.
- With `SSD1306_POWER_UP_EN` undefined: `busy`=0 and `oled_rst_n`=1 from the first cycle after reset. `frame_start` at cycle 0 gives `sr_start` with `sr_data`=21 at cycle 1.
